// File: rtl/pwm_capture_pkg.sv
// Shared types and default widths for the PWM capture path.
// State encodings match the fan controller's capture FSM.
package pwm_capture_pkg;

    localparam int ADC_BITWIDTH_DEF = 4;
    localparam int CNT_BITWIDTH_DEF = 8;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bundle of the PWM capture block.
// master drives the measurement, slave consumes it.
interface pwm_capture_if #(
    parameter int ADC_BITWIDTH = 4,
    parameter int CNT_BITWIDTH = 8
);

    logic [CNT_BITWIDTH-1:0] highCount_o;
    logic [CNT_BITWIDTH-1:0] periodCount_o;
    logic [ADC_BITWIDTH-1:0] duty_o;
    logic                    valid_o;
    logic                    stuck_o;
    logic                    overrun_o;

    modport master (
        output highCount_o,
        output periodCount_o,
        output duty_o,
        output valid_o,
        output stuck_o,
        output overrun_o
    );

    modport slave (
        input highCount_o,
        input periodCount_o,
        input duty_o,
        input valid_o,
        input stuck_o,
        input overrun_o
    );

endinterface

// File: rtl/pwm_capture_divider.sv
// Restoring divider producing floor(num * 2^ADC_BITWIDTH / den),
// one quotient bit per clock; requires num < den.
module pwm_duty_divider #(
    parameter int ADC_BITWIDTH = 4,
    parameter int CNT_BITWIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start,
    input  logic [CNT_BITWIDTH-1:0] numerator,
    input  logic [CNT_BITWIDTH-1:0] denominator,
    output logic                    busy,
    output logic                    done,
    output logic [ADC_BITWIDTH-1:0] quotient
);

    localparam int IW = $clog2(ADC_BITWIDTH + 1);
    localparam logic [IW-1:0] LAST = IW'(ADC_BITWIDTH - 1);

    logic [CNT_BITWIDTH:0]   rem;
    logic [CNT_BITWIDTH:0]   rem_sh;
    logic [CNT_BITWIDTH-1:0] den;
    logic [IW-1:0]           iter;
    logic                    take;

    // rem < den always, so the shifted remainder fits one extra bit
    always_comb begin
        rem_sh = rem << 1;
        take   = rem_sh >= {1'b0, den};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            iter     <= '0;
            rem      <= '0;
            den      <= '0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem      <= take ? rem_sh - {1'b0, den} : rem_sh;
                quotient <= (quotient << 1) | ADC_BITWIDTH'(take);
                iter     <= iter + 1'b1;
                if (iter == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                busy     <= 1'b1;
                iter     <= '0;
                rem      <= {1'b0, numerator};
                den      <= denominator;
                quotient <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an external PWM in clock-enable
// ticks and reports the duty cycle in the ADC number format.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
    parameter int CNT_BITWIDTH = CNT_BITWIDTH_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           clk_en_i,
    input  logic           pwm_i,
    pwm_capture_if.master  result
);

    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);
    localparam logic [CNT_BITWIDTH-1:0] CNT_TO  = CNT_BITWIDTH'(TIMEOUT);

    logic                    sync_q;
    logic                    s;
    logic                    p;
    logic                    rise;
    logic                    fall;
    cap_state_t              state;
    cap_state_t              state_nxt;
    logic [CNT_BITWIDTH-1:0] high_cnt;
    logic [CNT_BITWIDTH-1:0] per_cnt;
    logic [CNT_BITWIDTH-1:0] high_nxt;
    logic [CNT_BITWIDTH-1:0] per_nxt;
    logic [CNT_BITWIDTH-1:0] cap_high;
    logic [CNT_BITWIDTH-1:0] cap_per;
    logic                    capture;
    logic                    stuck_entry;
    logic                    stuck_exit;
    logic                    div_start;
    logic                    div_busy;
    logic                    div_done;
    logic [ADC_BITWIDTH-1:0] div_q;
    logic                    stuck_pend;
    logic                    pend_level;
    logic                    stuck_level;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            p      <= 1'b0;
        end else begin
            sync_q <= pwm_i;
            s      <= sync_q;
            if (clk_en_i) p <= s;
        end
    end

    assign rise = clk_en_i & s & ~p;
    assign fall = clk_en_i & ~s & p;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            high_cnt <= '0;
            per_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            high_cnt <= high_nxt;
            per_cnt  <= per_nxt;
        end
    end

    // In IDLE per_cnt doubles as the no-edge tick counter
    always_comb begin
        state_nxt   = state;
        high_nxt    = high_cnt;
        per_nxt     = per_cnt;
        capture     = 1'b0;
        stuck_entry = 1'b0;
        stuck_exit  = 1'b0;
        if (clk_en_i) begin
            unique case (state)
                IDLE, HIGH, LOW: begin
                    if (rise) begin
                        capture   = (state == LOW);
                        state_nxt = HIGH;
                        high_nxt  = CNT_ONE;
                        per_nxt   = CNT_ONE;
                    end else begin
                        per_nxt = per_cnt + CNT_ONE;
                        if (state == HIGH) begin
                            if (fall) state_nxt = LOW;
                            else      high_nxt  = high_cnt + CNT_ONE;
                        end
                        if (per_nxt == CNT_TO) begin
                            state_nxt   = STUCK;
                            stuck_entry = 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (rise) begin
                        stuck_exit = 1'b1;
                        state_nxt  = HIGH;
                        high_nxt   = CNT_ONE;
                        per_nxt    = CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign div_start = capture & ~div_busy;

    pwm_duty_divider #(
        .ADC_BITWIDTH (ADC_BITWIDTH),
        .CNT_BITWIDTH (CNT_BITWIDTH)
    ) u_div (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start       (div_start),
        .numerator   (high_cnt),
        .denominator (per_cnt),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_q)
    );

    assign stuck_level = stuck_entry ? s : pend_level;

    // A stuck entry colliding with a divider result is replayed next clk
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            result.highCount_o   <= '0;
            result.periodCount_o <= '0;
            result.duty_o        <= '0;
            result.valid_o       <= 1'b0;
            result.stuck_o       <= 1'b0;
            result.overrun_o     <= 1'b0;
            cap_high             <= '0;
            cap_per              <= '0;
            stuck_pend           <= 1'b0;
            pend_level           <= 1'b0;
        end else begin
            result.valid_o <= 1'b0;
            if (capture && div_busy) result.overrun_o <= 1'b1;
            if (div_start) begin
                cap_high <= high_cnt;
                cap_per  <= per_cnt;
            end
            if (div_done) begin
                result.highCount_o   <= cap_high;
                result.periodCount_o <= cap_per;
                result.duty_o        <= div_q;
                result.valid_o       <= 1'b1;
                if (stuck_entry) begin
                    stuck_pend <= 1'b1;
                    pend_level <= s;
                end
            end else if (stuck_entry || stuck_pend) begin
                result.duty_o  <= {ADC_BITWIDTH{stuck_level}};
                result.stuck_o <= 1'b1;
                result.valid_o <= 1'b1;
                stuck_pend     <= 1'b0;
            end
            if (stuck_exit) begin
                result.stuck_o <= 1'b0;
                stuck_pend     <= 1'b0;
            end
        end
    end

endmodule
